// File: rtl/ue1_seq.sv
// ---------------------------------------------------------------------------
// ue1_seq
// Instruction sequencer for the UE-1 core. Holds the program counter, a
// one-deep fetch register and a 4-entry return-address stack. The core
// raises jmp / rtn / skip for the instruction currently sitting in the
// fetch register; the sequencer redirects the PC and squashes the word
// being fetched by loading NOP0 (0x00) into the fetch register.
//
// Ports
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   en         in   1  run enable, 0 freezes all state and ignores strobes
//   imem_data  in   8  instruction word {op, arg} read at imem_addr
//   jmp        in   1  jump to {arg, 4'h0}, pushing the return address
//   rtn        in   1  return to the address on top of the stack
//   skip       in   1  discard the next instruction
//   imem_addr  out  8  program counter
//   instr_op   out  4  opcode field of the fetch register
//   instr_arg  out  4  operand field of the fetch register
//   stk_err    out  1  sticky stack overflow / underflow flag
//   sp         out  3  stack occupancy 0..4
// ---------------------------------------------------------------------------
module ue1_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] imem_data,
    input  logic       jmp,
    input  logic       rtn,
    input  logic       skip,
    output logic [7:0] imem_addr,
    output logic [3:0] instr_op,
    output logic [3:0] instr_arg,
    output logic       stk_err,
    output logic [2:0] sp
);

    localparam logic [7:0] NOP0   = 8'h00;
    localparam logic [2:0] SP_MAX = 3'd4;

    logic [7:0] r_pc;
    logic [7:0] r_instr;
    logic [7:0] r_stk [0:3];
    logic [2:0] r_sp;
    logic       r_err;

    // Index of the top-of-stack entry. Only used when r_sp is 1..4, and the
    // 2-bit wrap turns sp=4 (low bits 00) into index 3.
    logic [1:0] w_top;
    assign w_top = r_sp[1:0] - 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= 8'h00;
            r_instr <= NOP0;
            r_sp    <= 3'd0;
            r_err   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_stk[i] <= 8'h00;
            end
        end else if (en) begin
            if (jmp) begin
                // r_pc already points past the jumping instruction, so it is
                // the correct return address.
                r_pc    <= {r_instr[3:0], 4'h0};
                r_instr <= NOP0;
                if (r_sp == SP_MAX) begin
                    // Full stack: drop the oldest entry to make room.
                    r_stk[0] <= r_stk[1];
                    r_stk[1] <= r_stk[2];
                    r_stk[2] <= r_stk[3];
                    r_stk[3] <= r_pc;
                    r_err    <= 1'b1;
                end else begin
                    r_stk[r_sp[1:0]] <= r_pc;
                    r_sp             <= r_sp + 3'd1;
                end
            end else if (rtn) begin
                r_instr <= NOP0;
                if (r_sp == 3'd0) begin
                    r_pc  <= 8'h00;
                    r_err <= 1'b1;
                end else begin
                    r_pc <= r_stk[w_top];
                    r_sp <= r_sp - 3'd1;
                end
            end else if (skip) begin
                r_pc    <= r_pc + 8'd1;
                r_instr <= NOP0;
            end else begin
                r_pc    <= r_pc + 8'd1;
                r_instr <= imem_data;
            end
        end
    end

    assign imem_addr = r_pc;
    assign instr_op  = r_instr[7:4];
    assign instr_arg = r_instr[3:0];
    assign stk_err   = r_err;
    assign sp        = r_sp;

endmodule

// File: doc/ue1_seq.md
UE1_SEQ -- requirements
Module: ue1_seq

Interface
REQ-001 SHALL have ports: clk input 1 system clock; rst_n input 1 asynchronous active-low reset.
REQ-002 SHALL have ports: en input 1 run enable (0 = stall); imem_data input 8 instruction word {op[7:4], arg[3:0]}, combinational read of imem_addr.
REQ-003 SHALL have ports: jmp, rtn, skip input 1 each, control strobes from the UE-1 core for the instruction currently presented.
REQ-004 SHALL have ports: imem_addr output 8 program counter; instr_op output 4 to core I3..I0; instr_arg output 4 operand field.
REQ-005 SHALL have ports: stk_err output 1 sticky stack fault; sp output 3 stack occupancy 0..4.
REQ-006 SHALL have one clock and an asynchronous active-low reset, named clk and rst_n as elsewhere in the codebase.

Function
REQ-007 SHALL hold an 8-bit PC driving imem_addr, and a fetch register {instr_op, instr_arg} driven only from flops.
REQ-008 SHALL, on each rising edge with en=1 and no strobe active, load the fetch register from imem_data and set PC to PC+1, with 0xFF wrapping to 0x00.
REQ-009 SHALL associate jmp, rtn and skip sampled at an edge with the instruction held in the fetch register during the preceding cycle.
REQ-010 SHALL, on jmp=1 at an edge, push PC onto the stack, set PC to {instr_arg, 4'h0}, and load the fetch register with 0x00 (NOP0), squashing the word being fetched.
REQ-011 SHALL, on rtn=1 at an edge with jmp=0, pop the stack into PC and load the fetch register with 0x00.
REQ-012 SHALL, on skip=1 at an edge with jmp=0 and rtn=0, advance PC to PC+1 and load 0x00 instead of imem_data, discarding exactly one instruction.
REQ-013 SHALL apply priority jmp > rtn > skip when strobes coincide, with lower-priority strobes ignored for that edge.
REQ-014 SHALL implement a 4-entry LIFO of 8-bit return addresses; sp counts valid entries.
REQ-015 SHALL, on push when sp=4, overwrite the oldest entry, keep sp=4 and set stk_err.
REQ-016 SHALL, on pop when sp=0, load PC with 0x00, keep sp=0 and set stk_err.
REQ-017 SHALL keep stk_err set until reset.
REQ-018 SHALL, with en=0, hold PC, the fetch register, the stack and sp unchanged and ignore all strobes.
REQ-019 SHALL impose one cycle of fetch latency: the word at address A appears on instr_op/instr_arg in the cycle after imem_addr=A.
REQ-020 SHALL contain no combinational path from jmp, rtn or skip to any output.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously force PC=0x00, instr_op=0x0, instr_arg=0x0, sp=0 and stk_err=0; stack contents are don't-care.
REQ-022 SHALL resume fetching from 0x00 on the first rising edge after rst_n deasserts with en=1.
REQ-023 SHALL treat reset asserted mid-jump or mid-return as fully overriding; no partial push or pop survives.

Verification
REQ-024 SHALL verify linear fetch:
- Stimulus: memory holds 0x11, 0x22, 0x33 at addresses 0..2.
- Response: instr sequence 0x00, 0x11, 0x22, 0x33; PC 0,1,2,3.
REQ-025 SHALL verify jump and return:
- Stimulus: 0x5C at address 3; jmp pulsed while it is presented; later rtn pulsed.
- Response: PC=0xC0, sp=1, NOP inserted on jump; after rtn, PC=0x04, sp=0, NOP inserted.
REQ-026 SHALL verify skip:
- Stimulus: skip pulsed while the word at address 5 is presented.
- Response: word 6 never appears; NOP shown instead; next instruction is word 7.
REQ-027 SHALL verify stack overflow and underflow:
- Stimulus: 5 nested jmps.
- Response: sp=4, stk_err=1.
- Stimulus: after reset, rtn with sp=0.
- Response: PC=0x00, stk_err=1.
REQ-028 SHALL verify priority and stall:
- Stimulus: jmp+rtn+skip pulsed together.
- Response: jump taken only, sp increments by 1.
- Stimulus: en=0 for 3 cycles with strobes toggling.
- Response: all state frozen.
REQ-029 SHALL verify async reset:
- Stimulus: rst_n pulsed low between clock edges while sp=2 and PC=0x47.
- Response: outputs zero immediately; fetch restarts at 0x00.
